ula32_arbiter: RTL and testbench

- Shares one combinational ula32 (32-bit ALU, 2-bit ALUcontrol, 4-bit ALUflags) among NREQ requesters.
- Round-robin arbitration; valid/ready handshakes on every requester port and on the single response port.
- Two register stages: operand stage, then result stage. Full throughput of one operation per cycle.
- Sits between instruction-issue sources (execute units, test sequencers) and the shared ALU.

---
 rtl/ula32_pkg.sv | 18 +
 rtl/ula32.sv | 39 +++
 rtl/ula32_arbiter_rr_arbiter.sv | 30 +++
 rtl/ula32_arbiter.sv | 97 +++++++++
 tb/tb_ula32_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ula32_pkg.sv
// Shared definitions for the ula32 ALU and the arbiter that time-shares it.
package ula32_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/ula32.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags.
module ula32
    import ula32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        alu_flags
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] b_mux;
    logic              arith;
    alu_op_t           op;

    always_comb begin
        op    = alu_op_t'(alu_control);
        arith = ~alu_control[1];
        // Subtraction as a + ~b + 1, so C means "no borrow".
        b_mux = alu_control[0] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_mux} + {{DATA_W{1'b0}}, alu_control[0]};

        case (op)
            ALU_ADD, ALU_SUB: result = sum[DATA_W-1:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            default:          result = '0;
        endcase

        alu_flags         = '0;
        alu_flags[FLAG_N] = result[DATA_W-1];
        alu_flags[FLAG_Z] = (result == '0);
        alu_flags[FLAG_C] = arith & sum[DATA_W];
        alu_flags[FLAG_V] = arith & ~(a[DATA_W-1] ^ b[DATA_W-1] ^ alu_control[0])
                                  & (a[DATA_W-1] ^ sum[DATA_W-1]);
    end

endmodule

// File: rtl/ula32_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from last+1.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IDW'((32'(last) + off) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/ula32_arbiter.sv
// Shares one ula32 among NREQ valid/ready requesters: round-robin grant,
// operand register stage, result register stage, one op per cycle sustained.
module ula32_arbiter
    import ula32_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*2-1:0]      req_ctrl,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic [3:0]             rsp_flags
);

    logic              op_valid_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [1:0]        op_ctrl_q;
    logic [IDW-1:0]    op_id_q;
    logic [IDW-1:0]    last_q;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              out_free;
    logic              op_free;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    ula32 u_ula32 (
        .a           (op_a_q),
        .b           (op_b_q),
        .alu_control (op_ctrl_q),
        .result      (alu_result),
        .alu_flags   (alu_flags)
    );

    always_comb begin
        out_free  = ~rsp_valid | rsp_ready;
        op_free   = ~op_valid_q | out_free;
        // Held low during reset so nothing is offered while state is being cleared.
        req_ready = grant & {NREQ{op_free & rst_n}};
        accept    = |req_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_ctrl_q  <= '0;
            op_id_q    <= '0;
            last_q     <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                op_a_q    <= req_a[grant_idx*DATA_W +: DATA_W];
                op_b_q    <= req_b[grant_idx*DATA_W +: DATA_W];
                op_ctrl_q <= req_ctrl[grant_idx*2 +: 2];
                op_id_q   <= grant_idx;
                last_q    <= grant_idx;
            end
            op_valid_q <= accept | (op_valid_q & ~out_free);

            if (op_valid_q && out_free) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= op_id_q;
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end else if (out_free) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula32_arbiter.sv
// Directed bench for ula32_arbiter with NREQ=2; inputs change and outputs are sampled on negedge.
module tb_ula32_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    int n_cmp;
    int n_err;
    logic [31:0] exp_res [2];
    logic [3:0]  exp_flg [2];

    ula32_arbiter #(.NREQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ctrl[i*2 +: 2] = c;
    endtask

    task automatic chk_rsp(input string tag, input logic [0:0] id, input logic [31:0] res,
                           input logic [3:0] flg);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
        chk({tag, "_result"}, 64'(rsp_result), 64'(res));
        chk({tag, "_flags"}, 64'(rsp_flags), 64'(flg));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;

        // Reset state, with requests already pending
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_result", 64'(rsp_result), 64'd0);
        chk("rst_flags", 64'(rsp_flags), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Single op: 5 + 3
        rst_n     = 1'b1;
        req_valid = 2'b01;
        set_req(0, 32'd5, 32'd3, 2'b00);
        #1 chk("t1_ready", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk("t1_latency", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk_rsp("t1", 1'b0, 32'h0000_0008, 4'b0000);

        // Overflow and zero on requester 1
        set_req(1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
        req_valid = 2'b10;
        #1 chk("t2_ready_a", 64'(req_ready), 64'b10);
        @(negedge clk);
        chk("t2_drained", 64'(rsp_valid), 64'd0);
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        #1 chk("t2_ready_b", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid = 2'b00;
        chk_rsp("t2_ovf", 1'b1, 32'h8000_0000, 4'b1001);
        @(negedge clk);
        chk_rsp("t2_zero", 1'b1, 32'h0000_0000, 4'b0110);
        @(negedge clk);
        chk("t2_idle", 64'(rsp_valid), 64'd0);

        // Fairness: req0 SUB 0x10-3, req1 AND, both held valid for six accepts
        set_req(0, 32'h0000_0010, 32'h0000_0003, 2'b01);
        set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10);
        exp_res[0] = 32'h0000_000D; exp_flg[0] = 4'b0010;
        exp_res[1] = 32'h00F0_00F0; exp_flg[1] = 4'b0000;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("t3_ready%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            if (i >= 2) chk_rsp($sformatf("t3_rsp%0d", i - 2), 1'((i - 2) % 2),
                                exp_res[(i - 2) % 2], exp_flg[(i - 2) % 2]);
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk_rsp("t3_rsp4", 1'b0, exp_res[0], exp_flg[0]);
        @(negedge clk);
        chk_rsp("t3_rsp5", 1'b1, exp_res[1], exp_flg[1]);
        @(negedge clk);
        chk("t3_idle", 64'(rsp_valid), 64'd0);

        // Backpressure: req0 OR, req1 ADD with carry out
        rsp_ready = 1'b0;
        set_req(0, 32'h0000_FF00, 32'h00FF_0000, 2'b11);
        set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        req_valid = 2'b11;
        #1 chk("t4_ready0", 64'(req_ready), 64'b01);
        @(negedge clk);
        chk("t4_noresp", 64'(rsp_valid), 64'd0);
        #1 chk("t4_ready1", 64'(req_ready), 64'b10);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_rsp($sformatf("t4_hold%0d", k), 1'b0, 32'h00FF_FF00, 4'b0000);
            #1 chk($sformatf("t4_full%0d", k), 64'(req_ready), 64'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk_rsp("t4_rel", 1'b0, 32'h00FF_FF00, 4'b0000);
        #1 chk("t4_resume", 64'(req_ready), 64'b01);
        @(negedge clk);
        chk_rsp("t4_drain1", 1'b1, 32'hFFFF_FFFE, 4'b1010);
        #1 chk("t4_rr", 64'(req_ready), 64'b10);
        req_valid = 2'b00;
        @(negedge clk);
        chk_rsp("t4_drain2", 1'b0, 32'h00FF_FF00, 4'b0000);
        @(negedge clk);
        chk("t4_idle", 64'(rsp_valid), 64'd0);

        // Withdrawal: pointer sits at 0; req1 appears for one stalled cycle then leaves
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd2, 2'b00);
        set_req(1, 32'd2, 32'd5, 2'b01);
        req_valid = 2'b01;
        #1 chk("t5_ready0", 64'(req_ready), 64'b01);
        @(negedge clk);
        chk("t5_noresp", 64'(rsp_valid), 64'd0);
        #1 chk("t5_ready1", 64'(req_ready), 64'b01);
        @(negedge clk);
        chk_rsp("t5_stall", 1'b0, 32'd3, 4'b0000);
        req_valid = 2'b10;
        #1 chk("t5_wd_ready", 64'(req_ready), 64'b00);
        @(negedge clk);
        req_valid = 2'b00;
        chk_rsp("t5_hold", 1'b0, 32'd3, 4'b0000);
        @(negedge clk);
        // Unchanged pointer (0) puts req1 first once both compete
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1 chk("t5_ptr", 64'(req_ready), 64'b10);
        @(negedge clk);
        chk_rsp("t5_second", 1'b0, 32'd3, 4'b0000);
        #1 chk("t5_next", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        @(negedge clk);
        chk_rsp("t5_sub", 1'b1, 32'hFFFF_FFFD, 4'b1000);
        @(negedge clk);
        chk("t5_idle", 64'(rsp_valid), 64'd0);

        // Reset mid-flight with both stages full
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("t6_full_valid", 64'(rsp_valid), 64'd1);
        chk("t6_full_ready", 64'(req_ready), 64'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
        chk("t6_rst_result", 64'(rsp_result), 64'd0);
        chk("t6_rst_flags", 64'(rsp_flags), 64'd0);
        chk("t6_rst_id", 64'(rsp_id), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'b00);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1 chk("t6_first", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk("t6_nostale", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk_rsp("t6_rsp", 1'b0, 32'd3, 4'b0000);
        @(negedge clk);
        chk("t6_idle", 64'(rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
